// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//
// Iterative multiply/divide unit in the EX stage. It owns the architectural
// HI/LO registers.
//   - MULT, MULTU, DIV and DIVU take WIDTH+1 cycles: WIDTH iterations followed
//     by one sign-fix cycle.
//   - MTHI and MTLO write HI or LO in a single cycle while the unit is idle.
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high; clears all state, including HI/LO
//   valid   : an R-type instruction is in EX; qualifies funct
//   funct   : 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
//   rs_val  : multiplicand, dividend, or MTHI/MTLO source
//   rt_val  : multiplier or divisor
//   busy    : operation in flight; drives the pipeline stall (registered)
//   done    : one-cycle pulse once HI/LO hold a new mul/div result
//   hi, lo  : architectural HI/LO registers, read by the MFHI/MFLO result mux
// ---------------------------------------------------------------------------
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [5:0]       F_MTHI     = 6'h11;
  localparam logic [5:0]       F_MTLO     = 6'h13;
  localparam logic [WIDTH-1:0] MIN_INT    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 op_div_q, op_div_d;
  logic                 neg_res_q, neg_res_d;   // negate product / quotient
  logic                 neg_rem_q, neg_rem_d;   // negate remainder
  logic                 div_zero_q, div_zero_d;
  logic                 ovf_q, ovf_d;           // signed -2^(W-1) / -1
  logic [WIDTH-1:0]     rs_orig_q, rs_orig_d;   // HI result on divide by zero
  logic [WIDTH-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // -------------------------------------------------------------------------
  // Issue decode
  // -------------------------------------------------------------------------
  logic             is_muldiv;
  logic             is_mthi;
  logic             is_mtlo;
  logic             op_div_in;
  logic             op_signed_in;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  // funct 0x18..0x1B share the upper four bits; bit 1 selects divide and
  // bit 0 selects the unsigned variant.
  assign is_muldiv    = valid && (funct[5:2] == 4'b0110);
  assign is_mthi      = valid && (funct == F_MTHI);
  assign is_mtlo      = valid && (funct == F_MTLO);
  assign op_div_in    = funct[1];
  assign op_signed_in = ~funct[0];

  assign rs_neg = op_signed_in & rs_val[WIDTH-1];
  assign rt_neg = op_signed_in & rt_val[WIDTH-1];
  // Two's-complement negation of -2^(W-1) yields 2^(W-1), which is exactly
  // its magnitude when the iteration treats it as unsigned.
  assign rs_mag = rs_neg ? ({WIDTH{1'b0}} - rs_val) : rs_val;
  assign rt_mag = rt_neg ? ({WIDTH{1'b0}} - rt_val) : rt_val;

  // -------------------------------------------------------------------------
  // Iteration datapath
  // -------------------------------------------------------------------------
  // Multiply: acc = {partial product, remaining multiplier bits}. Each cycle
  // conditionally adds the multiplicand to the upper half and shifts right;
  // the carry out of the add becomes the new MSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  // Shift left by one, try to subtract the divisor from the upper W+1 bits;
  // on success keep the difference and shift in a 1, otherwise shift in a 0.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // -------------------------------------------------------------------------
  // Sign fix
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  assign prod_fixed = neg_res_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
  assign quo_fixed  = neg_res_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0])
                                : acc_q[WIDTH-1:0];
  assign rem_fixed  = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                                : acc_q[2*WIDTH-1:WIDTH];

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every *_d gets its hold value first so that no path through the
  // case statement leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_div_d   = op_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    rs_orig_d  = rs_orig_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        if (is_muldiv) begin
          state_d    = CALC;
          count_d    = '0;
          busy_d     = 1'b1;
          op_div_d   = op_div_in;
          neg_res_d  = rs_neg ^ rt_neg;
          neg_rem_d  = rs_neg;
          div_zero_d = op_div_in && (rt_val == '0);
          ovf_d      = op_div_in && op_signed_in
                       && (rs_val == MIN_INT) && (rt_val == '1);
          rs_orig_d  = rs_val;
          if (op_div_in) begin
            opnd_d = rt_mag;
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
          end else begin
            opnd_d = rs_mag;
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
          end
        end else if (is_mthi) begin
          hi_d = rs_val;
        end else if (is_mtlo) begin
          lo_d = rs_val;
        end
      end

      CALC: begin
        acc_d   = op_div_q ? div_next : mul_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST_COUNT) begin
          state_d = FIX;
          count_d = '0;
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_div_q) begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = rs_orig_q;
          lo_d = '1;
        end else if (ovf_q) begin
          hi_d = '0;
          lo_d = MIN_INT;
        end else begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its *_d input regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      rs_orig_q  <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_div_q   <= op_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      rs_orig_q  <= rs_orig_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
//
// Scoreboard bench for ex_muldiv. The stimulus side issues operations and
// pushes the expected {hi, lo} for every mul/div; a monitor pops and compares
// whenever done is seen, and also checks busy length and done shape.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam int         LATENCY = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .funct  (funct),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from the architectural rules, using 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT: begin
        p = sa * sb;
        return 64'(p);
      end
      F_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      F_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      4:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 14));
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) check("wait_idle_timeout", 64'(busy), 64'(0));
  endtask

  // Drive one instruction for one cycle. use_exp selects the given expected
  // result instead of the reference model.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [63:0] exp);
    logic [63:0] e;
    bit          is_md;
    wait_idle();
    is_md  = (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
    e      = use_exp ? exp : model(f, a, b);
    valid  = 1'b1;
    funct  = f;
    rs_val = a;
    rt_val = b;
    if (is_md) begin
      exp_q.push_back(e);
      model_hi = e[63:32];
      model_lo = e[31:0];
    end else if (f == F_MTHI) begin
      model_hi = a;
    end else if (f == F_MTLO) begin
      model_lo = a;
    end
    @(negedge clk);
    valid = 1'b0;
    funct = 6'h00;
    if (is_md) begin
      check("busy_after_start", 64'(busy), 64'(1));
    end else begin
      check("busy_idle_op", 64'(busy), 64'(0));
      check("hi_idle_op", 64'(hi), 64'(model_hi));
      check("lo_idle_op", 64'(lo), 64'(model_lo));
    end
  endtask

  // Monitor: scoreboard pop on done, busy length and done pulse shape.
  int   busy_len  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy_len  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        check("busy_length", 64'(busy_len), 64'(LATENCY));
        busy_len = 0;
      end
      if (done) begin
        check("done_single_pulse", 64'(prev_done), 64'(0));
        check("busy_low_at_done", 64'(busy), 64'(0));
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'(0));
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("result_hi", 64'(hi), 64'(e[63:32]));
          check("result_lo", 64'(lo), 64'(e[31:0]));
        end
      end
      prev_done = done;
    end
  end

  initial begin
    reset  = 1'b1;
    valid  = 1'b0;
    funct  = 6'h00;
    rs_val = '0;
    rt_val = '0;
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with literal expectations.
    issue(F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFE, 32'h0000_0001});
    issue(F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h0000_0001});
    issue(F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(F_DIVU,  32'h0000_0007, 32'h0000_0000, 1'b1, {32'h0000_0007, 32'hFFFF_FFFF});
    issue(F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
    issue(F_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0000_0000});
    issue(F_MTHI,  32'h1234_5678, 32'h0,         1'b0, 64'h0);
    check("mthi_value", 64'(hi), 64'(32'h1234_5678));
    issue(F_MTLO,  32'h0BAD_F00D, 32'h0,         1'b0, 64'h0);
    check("mtlo_value", 64'(lo), 64'(32'h0BAD_F00D));
    issue(6'h20,   32'hDEAD_BEEF, 32'h1,         1'b0, 64'h0);

    // Instructions presented while busy must be ignored.
    issue(F_MULT, 32'h0000_0006, 32'hFFFF_FFFB, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFE2});
    valid  = 1'b1;
    funct  = F_MTLO;
    rs_val = 32'h0000_AAAA;
    rt_val = 32'h0;
    repeat (3) @(negedge clk);
    funct  = F_DIVU;
    rs_val = 32'd100;
    rt_val = 32'd7;
    repeat (3) @(negedge clk);
    valid  = 1'b0;
    funct  = 6'h00;

    // A DIVU presented in the done cycle starts at the following edge.
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("done_seen_before_b2b", 64'(done), 64'(1));
    issue(F_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});

    // Asynchronous reset mid-CALC, between clock edges.
    issue(F_MULT, 32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    #1;
    check("async_reset_busy", 64'(busy), 64'(0));
    check("async_reset_hi", 64'(hi), 64'(0));
    check("async_reset_lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(F_MULTU, 32'd3, 32'd5, 1'b1, {32'd0, 32'd15});

    // Randomized mix against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] f;
      case ($urandom_range(0, 9))
        0, 1:    f = F_MULT;
        2, 3:    f = F_MULTU;
        4, 5:    f = F_DIV;
        6, 7:    f = F_DIVU;
        8:       f = ($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO;
        default: f = 6'h2A;
      endcase
      issue(f, rand_opnd(), rand_opnd(), 1'b0, 64'h0);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("final_hi", 64'(hi), 64'(model_hi));
    check("final_lo", 64'(lo), 64'(model_lo));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
